// File: rtl/pixel_clk_div_if.sv
// ---------------------------------------------------------------------------
// pixel_clk_div_if
// Divisor load channel for pixel_clk_div.
//   div_in     : requested divisor (master -> slave)
//   div_valid  : div_in valid (master -> slave)
//   div_ready  : divider can accept a divisor (slave -> master)
//   div_err    : one-cycle pulse, rejected divisor (slave -> master)
//   div_active : divisor currently in effect (slave -> master)
// ---------------------------------------------------------------------------
interface pixel_clk_div_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             div_err;
    logic [CNT_W-1:0] div_active;

    modport master (
        output div_in,
        output div_valid,
        input  div_ready,
        input  div_err,
        input  div_active
    );

    modport slave (
        input  div_in,
        input  div_valid,
        output div_ready,
        output div_err,
        output div_active
    );
endinterface

// File: rtl/pixel_clk_div.sv
// ---------------------------------------------------------------------------
// pixel_clk_div
// Runtime-programmable clock-enable / divided-clock generator.
// Produces a one-cycle clk_en strobe and a registered pixel_clk square wave
// (high floor(N/2), low ceil(N/2)) from in_clk for any divisor
// N = MIN_DIV .. 2^CNT_W-1. A new divisor is taken through the bus channel
// and applied only at a period boundary, so pixel_clk never glitches.
//
// Ports:
//   in_clk       : sole clock
//   reset        : synchronous, active-high
//   enable       : period counter advances only while high
//   sync_restart : (PIXEL_CLK_DIV_SYNC_RESTART_EN only) force a period start
//   bus          : divisor load channel (div_in/valid/ready/err/active)
//   clk_en       : one-cycle strobe per period, with pixel_clk rising edge
//   pixel_clk    : registered divided clock, use as data/enable only
//
// Optional feature macro: PIXEL_CLK_DIV_SYNC_RESTART_EN
//   When defined, adds sync_restart to phase-align to an external strobe.
// ---------------------------------------------------------------------------
module pixel_clk_div #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int MIN_DIV     = 2
) (
    input  logic              in_clk,
    input  logic              reset,
    input  logic              enable,
`ifdef PIXEL_CLK_DIV_SYNC_RESTART_EN
    input  logic              sync_restart,
`endif
    pixel_clk_div_if.slave    bus,
    output logic              clk_en,
    output logic              pixel_clk
);

    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV_V = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] pend_q,       pend_d;
    logic             pend_vld_q,   pend_vld_d;
    logic             div_ready_q,  div_ready_d;
    logic             div_err_q,    div_err_d;
    logic             clk_en_q,     clk_en_d;
    logic             pixel_clk_q,  pixel_clk_d;

    logic             restart;
    logic             term;
    logic             accept;

`ifdef PIXEL_CLK_DIV_SYNC_RESTART_EN
    assign restart = sync_restart;
`else
    assign restart = 1'b0;
`endif

    always_comb begin
        term   = enable && (restart || (cnt_q == div_active_q - ONE_V));
        accept = bus.div_valid && div_ready_q;

        // Period counter
        cnt_d = cnt_q;
        if (term) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + ONE_V;
        end

        // Pending slot. accept needs an empty slot and apply needs a full
        // one, so the two can never fire together: a value accepted on a
        // term cycle waits for the following term.
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        div_active_d = div_active_q;
        div_err_d    = 1'b0;
        if (term && pend_vld_q) begin
            div_active_d = pend_q;
            pend_vld_d   = 1'b0;
        end else if (accept) begin
            if (bus.div_in < MIN_DIV_V) begin
                div_err_d = 1'b1;
            end else begin
                pend_d     = bus.div_in;
                pend_vld_d = 1'b1;
            end
        end
        div_ready_d = !pend_vld_d;

        // Outputs are computed from the post-edge counter and divisor so the
        // new period's first cycle already uses the new half value.
        clk_en_d    = enable && (cnt_d == '0);
        pixel_clk_d = pixel_clk_q;
        if (enable) begin
            pixel_clk_d = (cnt_d < (div_active_d >> 1));
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            cnt_q        <= DEF_DIV_V - ONE_V;
            div_active_q <= DEF_DIV_V;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            div_ready_q  <= 1'b1;
            div_err_q    <= 1'b0;
            clk_en_q     <= 1'b0;
            pixel_clk_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            div_ready_q  <= div_ready_d;
            div_err_q    <= div_err_d;
            clk_en_q     <= clk_en_d;
            pixel_clk_q  <= pixel_clk_d;
        end
    end

    assign bus.div_ready  = div_ready_q;
    assign bus.div_err    = div_err_q;
    assign bus.div_active = div_active_q;
    assign clk_en         = clk_en_q;
    assign pixel_clk      = pixel_clk_q;

endmodule

// File: tb/tb_pixel_clk_div.sv
// ---------------------------------------------------------------------------
// tb_pixel_clk_div
// Directed bench for pixel_clk_div with default parameters (CNT_W=8,
// DEFAULT_DIV=4, MIN_DIV=2). Inputs change 1 ns after each rising edge and
// outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_pixel_clk_div;

    logic in_clk = 1'b0;
    logic reset;
    logic enable;
    logic clk_en;
    logic pixel_clk;
`ifdef PIXEL_CLK_DIV_SYNC_RESTART_EN
    logic sync_restart;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pixel_clk_div_if #(.CNT_W(8)) bus ();

    pixel_clk_div #(
        .CNT_W       (8),
        .DEFAULT_DIV (4),
        .MIN_DIV     (2)
    ) dut (
        .in_clk       (in_clk),
        .reset        (reset),
        .enable       (enable),
`ifdef PIXEL_CLK_DIV_SYNC_RESTART_EN
        .sync_restart (sync_restart),
`endif
        .bus          (bus.slave),
        .clk_en       (clk_en),
        .pixel_clk    (pixel_clk)
    );

    always #5 in_clk = ~in_clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // Advance one edge and check the two period outputs.
    task automatic cyc(input string tag, input logic en_exp, input logic pix_exp);
        step();
        check_eq({tag, ".clk_en"}, 32'(clk_en), 32'(en_exp));
        check_eq({tag, ".pixel_clk"}, 32'(pixel_clk), 32'(pix_exp));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".clk_en"},     32'(clk_en),         32'd0);
        check_eq({tag, ".pixel_clk"},  32'(pixel_clk),      32'd0);
        check_eq({tag, ".div_active"}, 32'(bus.div_active), 32'd4);
        check_eq({tag, ".div_ready"},  32'(bus.div_ready),  32'd1);
        check_eq({tag, ".div_err"},    32'(bus.div_err),    32'd0);
    endtask

    initial begin
        // Expected patterns, one entry per edge.
        logic [7:0] en4;
        logic [7:0] pix4;
        logic [9:0] en5;
        logic [9:0] pix5;
        en4  = 8'b1000_1000;    // MSB first: edges 1..8
        pix4 = 8'b1100_1100;
        en5  = 10'b00001_00001; // edges after the apply edge
        pix5 = 10'b10001_10001;

        reset         = 1'b1;
        enable        = 1'b0;
        bus.div_in    = '0;
        bus.div_valid = 1'b0;
`ifdef PIXEL_CLK_DIV_SYNC_RESTART_EN
        sync_restart  = 1'b0;
`endif
        step();
        step();
        check_reset_state("rst");

        // Default divide-by-4 from the first edge after release.
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("div4[%0d]", i), en4[7-i], pix4[7-i]);
        end
        check_eq("div4.div_active", 32'(bus.div_active), 32'd4);

        // cnt=3 now; next edge starts a period (cnt 0).
        cyc("p0", 1'b1, 1'b1);
        bus.div_in    = 8'd5;
        bus.div_valid = 1'b1;
        cyc("ld5", 1'b0, 1'b1);                  // accepted, cnt 1
        check_eq("ld5.div_ready", 32'(bus.div_ready), 32'd0);
        bus.div_in = 8'd9;                       // must be ignored
        cyc("ld9", 1'b0, 1'b0);                  // cnt 2
        check_eq("ld9.div_err", 32'(bus.div_err), 32'd0);
        bus.div_valid = 1'b0;
        cyc("old3", 1'b0, 1'b0);                 // cnt 3, old period finishing
        check_eq("old3.div_active", 32'(bus.div_active), 32'd4);
        check_eq("old3.div_ready", 32'(bus.div_ready), 32'd0);
        cyc("apply", 1'b1, 1'b1);                // apply edge
        check_eq("apply.div_active", 32'(bus.div_active), 32'd5);
        check_eq("apply.div_ready", 32'(bus.div_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("div5[%0d]", i), en5[9-i], pix5[9-i]);
        end
        check_eq("div5.div_active", 32'(bus.div_active), 32'd5);

        // Rejected divisors 1 then 0 (cnt=0 here).
        bus.div_in    = 8'd1;
        bus.div_valid = 1'b1;
        cyc("err1", 1'b0, 1'b1);                 // cnt 1
        check_eq("err1.div_err", 32'(bus.div_err), 32'd1);
        check_eq("err1.div_ready", 32'(bus.div_ready), 32'd1);
        bus.div_in = 8'd0;
        cyc("err0", 1'b0, 1'b0);                 // cnt 2
        check_eq("err0.div_err", 32'(bus.div_err), 32'd1);
        bus.div_valid = 1'b0;
        cyc("err_end", 1'b0, 1'b0);              // cnt 3
        check_eq("err_end.div_err", 32'(bus.div_err), 32'd0);
        check_eq("err_end.div_active", 32'(bus.div_active), 32'd5);
        cyc("pre_hold4", 1'b0, 1'b0);            // cnt 4
        cyc("pre_hold0", 1'b1, 1'b1);            // cnt 0

        // Enable low for 7 cycles: hold, no strobe.
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc($sformatf("hold[%0d]", i), 1'b0, 1'b1);
        end
        enable = 1'b1;
        cyc("resume1", 1'b0, 1'b1);              // cnt 1
        cyc("resume2", 1'b0, 1'b0);
        cyc("resume3", 1'b0, 1'b0);
        cyc("resume4", 1'b0, 1'b0);
        cyc("resume0", 1'b1, 1'b1);

        // Reset with a divisor pending discards it.
        bus.div_in    = 8'd7;
        bus.div_valid = 1'b1;
        cyc("ld7", 1'b0, 1'b1);
        check_eq("ld7.div_ready", 32'(bus.div_ready), 32'd0);
        bus.div_valid = 1'b0;
        reset = 1'b1;
        step();
        check_reset_state("rst2");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("post_rst[%0d]", i), en4[7-i], pix4[7-i]);
        end
        // Edge 5 was a term; a surviving pending 7 would have applied there.
        check_eq("post_rst.div_active", 32'(bus.div_active), 32'd4);
        check_eq("post_rst.div_ready", 32'(bus.div_ready), 32'd1);

`ifdef PIXEL_CLK_DIV_SYNC_RESTART_EN
        cyc("sr1", 1'b0, 1'b1);                  // cnt 1
        cyc("sr2", 1'b0, 1'b0);                  // cnt 2
        sync_restart = 1'b1;
        cyc("sr_fire", 1'b1, 1'b1);              // forced period start
        sync_restart = 1'b0;
        cyc("sr_next", 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_clk_div.md
Name: pixel_clk_div

Overview:
- Parametrised, runtime-programmable clock-enable and divided-clock generator. Successor to the fixed divide-by-4 pixel clock divider.
- Generates a one-cycle `clk_en` strobe and a registered `pixel_clk` square wave from `in_clk` for any divisor MIN_DIV..2^CNT_W-1.
- The divisor is loaded through a valid/ready handshake and applied glitch-free at the next period boundary.
- Sits between the board clock and VGA timing / pixel pipelines. Default config gives 25 MHz from 100 MHz.

Parameters:
- CNT_W, 8, width of divisor and period counter.
- DEFAULT_DIV, 4, divisor active after reset. Must satisfy MIN_DIV <= DEFAULT_DIV <= 2^CNT_W-1.
- MIN_DIV, 2, smallest legal divisor. Must be >= 2.

Ports:
- in_clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  counter advances only while high.
- div_in  input  CNT_W  requested divisor.
- div_valid  input  1  div_in valid.
- div_ready  output  1  block can accept a divisor.
- div_err  output  1  one-cycle pulse: rejected divisor (< MIN_DIV).
- div_active  output  CNT_W  divisor currently in effect.
- clk_en  output  1  one-cycle strobe per output period, aligned to the pixel_clk rising edge.
- pixel_clk  output  1  registered divided clock; use as data/enable, not as a clock tree root.

Behaviour:
- One clock, in_clk. Reset is synchronous and active-high on `reset`. All outputs are registered.
- Reset values:
  - cnt = DEFAULT_DIV-1, div_active = DEFAULT_DIV.
  - pending empty, div_ready = 1.
  - div_err = 0, clk_en = 0, pixel_clk = 0.
- Terminal condition: term = enable && (cnt == div_active-1).
- next_cnt:
  - term: 0.
  - enable && !term: cnt+1.
  - !enable: cnt (hold).
- Registered outputs each edge:
  - clk_en <= enable && (next_cnt == 0).
  - pixel_clk <= (next_cnt < (div_active_next >> 1)). div_active_next is the divisor in effect after this edge.
  - While enable is low: pixel_clk holds, clk_en = 0.
- Period and duty:
  - Period = N = div_active cycles.
  - pixel_clk high floor(N/2) cycles, low ceil(N/2).
  - clk_en and the pixel_clk rising edge occur on the same edge.
- First edge after reset release with enable=1 wraps cnt to 0, so clk_en=1 and pixel_clk=1 immediately. No runt pulse.
- Handshake: accept = div_valid && div_ready.
  - If div_in < MIN_DIV: div_err=1 next cycle. Nothing stored; div_ready stays 1.
  - Otherwise: pending <= div_in, div_ready <= 0.
  - While pending is occupied: div_valid is ignored and div_err stays 0.
- Apply: on a term cycle with pending occupied:
  - div_active <= pending, cnt <= 0, pending cleared.
  - div_ready = 1 from the next cycle.
  - The new period starts at that edge: pixel_clk uses the new half value, clk_en=1.
- Simultaneous accept and term in the same cycle: the value only becomes pending. It applies at the following term, never the current one.
- enable low with pending occupied: pending waits; it applies at the first term after enable returns.
- Reset mid-operation: pending is discarded and all state returns to reset values on that edge. Reset has priority over every other event.
- div_in = 2^CNT_W-1 is legal. cnt never exceeds div_active-1, so there is no overflow.

Optional Feature:
- Macro: PIXEL_CLK_DIV_SYNC_RESTART_EN.
- Defined: adds input `sync_restart` (1 bit).
  - While enable && sync_restart: next_cnt = 0 and the cycle is treated as term. clk_en=1 and pixel_clk=1 on the next edge, and any pending divisor is applied.
  - Used to phase-align to an external frame strobe.
- Undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset, enable=1, defaults -> clk_en pulses every 4 cycles starting the first edge after reset; pixel_clk pattern 1,1,0,0 repeating; div_active=4.
- Load div_in=5 mid-period -> div_ready drops the next cycle; the old 4-cycle period completes; then pixel_clk pattern 1,1,0,0,0 and clk_en every 5 cycles; div_ready returns to 1 after the apply edge.
- div_in=1 (and 0) with div_valid -> div_err pulses exactly 1 cycle; div_active unchanged; div_ready stays 1.
- Second div_valid (div_in=9) while 5 is pending -> ignored; only 5 is applied; no div_err.
- enable low for 7 cycles mid-period -> cnt/pixel_clk hold, clk_en=0; period resumes exactly where it stopped.
- Assert reset with a divisor pending -> pending discarded; after release the 4-cycle default resumes with clk_en on the first edge. With PIXEL_CLK_DIV_SYNC_RESTART_EN: sync_restart at cnt=2 -> clk_en=1 on the next edge.
